register_file_mp: RTL and testbench



---
 rtl/regfile_pkg.sv | 16 +
 rtl/regfile_read_port.sv | 83 ++++++++
 rtl/register_file_mp.sv | 91 +++++++++
 tb/tb_register_file_mp.sv | 389 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared definitions for the multi-port integer register file.
// Holds the default geometry, the address/data typedefs sized for that
// default geometry, and the address of the hardwired zero register.
package regfile_pkg;

  localparam int DEFAULT_XLEN = 32;
  localparam int DEFAULT_NREG = 32;
  localparam int DEFAULT_AW   = $clog2(DEFAULT_NREG);

  // Register 0 reads as zero and ignores writes when ZERO_REG is set
  localparam int ZERO_ADDR = 0;

  typedef logic [DEFAULT_AW-1:0]   reg_addr_t;
  typedef logic [DEFAULT_XLEN-1:0] reg_data_t;

endpackage

// File: rtl/regfile_read_port.sv
// One registered read port of register_file_mp.
// Decodes the read address, masks the zero register and out-of-range
// addresses, and holds its outputs while the port is disabled.
// Optional macro REGFILE_BYPASS_EN: a same-cycle write or pend_set to the
// address being read is forwarded into the read result (write-first).
// Without it the port returns the pre-edge array and pend state (read-first).
module regfile_read_port
  import regfile_pkg::*;
#(
  parameter int XLEN     = DEFAULT_XLEN,
  parameter int NREG     = DEFAULT_NREG,
  parameter int ZERO_REG = 1,
  parameter int AW       = $clog2(NREG)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            rd_en,
  input  logic [AW-1:0]   rd_addr,
  input  logic [XLEN-1:0] mem [NREG],
  input  logic [NREG-1:0] pend,
  input  logic            wr_ok,
  input  logic [AW-1:0]   wr_addr,
  input  logic [XLEN-1:0] wr_data,
  input  logic            ps_ok,
  input  logic [AW-1:0]   pend_addr,
  output logic [XLEN-1:0] rd_data,
  output logic            rd_busy
);

  logic            addr_ok;
  logic [XLEN-1:0] next_data;
  logic            next_busy;

  // The zero register and addresses beyond the array always read as idle zeros
  always_comb begin
    addr_ok = (int'(rd_addr) < NREG) &&
              !((ZERO_REG != 0) && (int'(rd_addr) == ZERO_ADDR));
  end

`ifdef REGFILE_BYPASS_EN
  // Forward the post-edge view: the write replaces data and clears busy, a pend_set wins
  always_comb begin
    next_data = mem[rd_addr];
    next_busy = pend[rd_addr];
    if (wr_ok && (wr_addr == rd_addr)) begin
      next_data = wr_data;
      next_busy = 1'b0;
    end
    if (ps_ok && (pend_addr == rd_addr)) begin
      next_busy = 1'b1;
    end
    if (!addr_ok) begin
      next_data = '0;
      next_busy = 1'b0;
    end
  end
`else
  logic unused_bypass;
  assign unused_bypass = ^{wr_ok, wr_addr, wr_data, ps_ok, pend_addr};

  // Return the pre-edge array and pend state, masked for zero/out-of-range
  always_comb begin
    next_data = mem[rd_addr];
    next_busy = pend[rd_addr];
    if (!addr_ok) begin
      next_data = '0;
      next_busy = 1'b0;
    end
  end
`endif

  // Output registers load on an enabled read and hold otherwise
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_data <= '0;
      rd_busy <= 1'b0;
    end else if (rd_en) begin
      rd_data <= next_data;
      rd_busy <= next_busy;
    end
  end

endmodule

// File: rtl/register_file_mp.sv
// Parametrised multi-read-port integer register file with registered
// reads and a per-register pending (scoreboard) bit.
// Optional macro REGFILE_BYPASS_EN selects write-first forwarding on
// same-cycle write/read hits; the default build is read-first.
module register_file_mp
  import regfile_pkg::*;
#(
  parameter  int XLEN     = DEFAULT_XLEN,
  parameter  int NREG     = DEFAULT_NREG,
  parameter  int NRD      = 2,
  parameter  int ZERO_REG = 1,
  localparam int AW       = $clog2(NREG)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NRD-1:0]      rd_en,
  input  logic [NRD*AW-1:0]   rd_addr,
  output logic [NRD*XLEN-1:0] rd_data,
  output logic [NRD-1:0]      rd_busy,
  input  logic                wr_en,
  input  logic [AW-1:0]       wr_addr,
  input  logic [XLEN-1:0]     wr_data,
  input  logic                pend_set,
  input  logic [AW-1:0]       pend_addr
);

  logic [XLEN-1:0] mem [NREG];
  logic [NREG-1:0] pend;
  logic            wr_ok;
  logic            ps_ok;

  // Writes and pend_set only take effect on real, writable registers
  always_comb begin
    wr_ok = wr_en &&
            (int'(wr_addr) < NREG) &&
            !((ZERO_REG != 0) && (int'(wr_addr) == ZERO_ADDR));
    ps_ok = pend_set &&
            (int'(pend_addr) < NREG) &&
            !((ZERO_REG != 0) && (int'(pend_addr) == ZERO_ADDR));
  end

  // Register array; reset clears every entry and drops any write on that edge
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NREG; i++) begin
        mem[i] <= '0;
      end
    end else if (wr_ok) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // Scoreboard: a write retires its register, a pend_set applied afterwards wins
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pend <= '0;
    end else begin
      if (wr_ok) begin
        pend[wr_addr] <= 1'b0;
      end
      if (ps_ok) begin
        pend[pend_addr] <= 1'b1;
      end
    end
  end

  // One independent registered read port per NRD
  for (genvar g = 0; g < NRD; g++) begin : g_rd
    regfile_read_port #(
      .XLEN     (XLEN),
      .NREG     (NREG),
      .ZERO_REG (ZERO_REG),
      .AW       (AW)
    ) u_port (
      .clk       (clk),
      .reset     (reset),
      .rd_en     (rd_en[g]),
      .rd_addr   (rd_addr[g*AW +: AW]),
      .mem       (mem),
      .pend      (pend),
      .wr_ok     (wr_ok),
      .wr_addr   (wr_addr),
      .wr_data   (wr_data),
      .ps_ok     (ps_ok),
      .pend_addr (pend_addr),
      .rd_data   (rd_data[g*XLEN +: XLEN]),
      .rd_busy   (rd_busy[g])
    );
  end

endmodule

// File: tb/tb_register_file_mp.sv
// Self-checking bench for register_file_mp (default geometry, 2 read ports).
// Directed scenarios check spec constants; a randomized run checks against
// an array-based reference model. Honours REGFILE_BYPASS_EN if defined.
module tb_register_file_mp;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  rd_en;
  logic [9:0]  rd_addr;
  logic [63:0] rd_data;
  logic [1:0]  rd_busy;
  logic        wr_en;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;
  logic        pend_set;
  logic [4:0]  pend_addr;

  int vectors     = 0;
  int miscompares = 0;

  // Reference model state: architectural registers, pending bits, expected outputs
  logic [31:0] m_mem [32];
  bit          m_pend [32];
  logic [31:0] e_data [2];
  bit          e_busy [2];

  register_file_mp dut (
    .clk       (clk),
    .reset     (reset),
    .rd_en     (rd_en),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data),
    .rd_busy   (rd_busy),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .pend_set  (pend_set),
    .pend_addr (pend_addr)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic model_clear();
    for (int i = 0; i < 32; i++) begin
      m_mem[i]  = 32'h0;
      m_pend[i] = 1'b0;
    end
    for (int p = 0; p < 2; p++) begin
      e_data[p] = 32'h0;
      e_busy[p] = 1'b0;
    end
  endtask

  // Apply the register file rules for one clock edge to the model
  task automatic model_edge();
    bit          w_ok, s_ok;
    logic [4:0]  a;
    w_ok = wr_en && (wr_addr != 5'd0);
    s_ok = pend_set && (pend_addr != 5'd0);
    for (int p = 0; p < 2; p++) begin
      if (rd_en[p]) begin
        a = rd_addr[p*5 +: 5];
        if (a == 5'd0) begin
          e_data[p] = 32'h0;
          e_busy[p] = 1'b0;
        end else begin
`ifdef REGFILE_BYPASS_EN
          e_data[p] = (w_ok && wr_addr == a) ? wr_data : m_mem[a];
          if (s_ok && pend_addr == a)      e_busy[p] = 1'b1;
          else if (w_ok && wr_addr == a)   e_busy[p] = 1'b0;
          else                             e_busy[p] = m_pend[a];
`else
          e_data[p] = m_mem[a];
          e_busy[p] = m_pend[a];
`endif
        end
      end
    end
    if (w_ok) begin
      m_mem[wr_addr]  = wr_data;
      m_pend[wr_addr] = 1'b0;
    end
    if (s_ok) m_pend[pend_addr] = 1'b1;
  endtask

  task automatic drive_idle();
    rd_en     = 2'b00;
    rd_addr   = 10'h0;
    wr_en     = 1'b0;
    wr_addr   = 5'h0;
    wr_data   = 32'h0;
    pend_set  = 1'b0;
    pend_addr = 5'h0;
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic set_read(input int p, input logic [4:0] a);
    rd_en[p]           = 1'b1;
    rd_addr[p*5 +: 5]  = a;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    drive_idle();
    model_clear();
    repeat (2) @(posedge clk);
    #1;
    for (int p = 0; p < 2; p++) begin
      vectors++;
      if (rd_data[p*32 +: 32] !== 32'h0 || rd_busy[p] !== 1'b0) begin
        miscompares++;
        $display("[TB] FAIL reset_initial port%0d: got %h/%b, expected 0/0", p, rd_data[p*32 +: 32], rd_busy[p]);
      end
    end
    reset = 1'b0;
    for (int i = 1; i < 32; i++) begin
      drive_idle();
      wr_en   = 1'b1;
      wr_addr = 5'(i);
      wr_data = 32'hA5A5_0000 + 32'(i);
      tick();
    end
    drive_idle();
    set_read(0, 5'd1);
    set_read(1, 5'd31);
    tick();
    vectors++;
    if (rd_data[31:0] !== 32'hA5A5_0001 || rd_data[63:32] !== 32'hA5A5_001F) begin
      miscompares++;
      $display("[TB] FAIL reset_fill: got %h %h, expected a5a50001 a5a5001f", rd_data[31:0], rd_data[63:32]);
    end
    // Write and pend in flight when reset arrives mid-cycle
    drive_idle();
    wr_en     = 1'b1;
    wr_addr   = 5'd4;
    wr_data   = 32'h1234_5678;
    pend_set  = 1'b1;
    pend_addr = 5'd6;
    #2;
    reset = 1'b1;
    #1;
    for (int p = 0; p < 2; p++) begin
      vectors++;
      if (rd_data[p*32 +: 32] !== 32'h0 || rd_busy[p] !== 1'b0) begin
        miscompares++;
        $display("[TB] FAIL reset_async port%0d: got %h/%b, expected 0/0", p, rd_data[p*32 +: 32], rd_busy[p]);
      end
    end
    @(posedge clk);
    #1;
    reset = 1'b0;
    model_clear();
    drive_idle();
    set_read(0, 5'd4);
    set_read(1, 5'd6);
    tick();
    for (int p = 0; p < 2; p++) begin
      vectors++;
      if (rd_data[p*32 +: 32] !== 32'h0 || rd_busy[p] !== 1'b0) begin
        miscompares++;
        $display("[TB] FAIL reset_lost_write port%0d: got %h/%b, expected 0/0", p, rd_data[p*32 +: 32], rd_busy[p]);
      end
    end
    drive_idle();
    set_read(0, 5'd1);
    set_read(1, 5'd31);
    tick();
    vectors++;
    if (rd_data !== 64'h0 || rd_busy !== 2'b00) begin
      miscompares++;
      $display("[TB] FAIL reset_cleared: got %h/%b, expected 0/00", rd_data, rd_busy);
    end
  endtask

  task automatic test_write_read();
    drive_idle();
    wr_en   = 1'b1;
    wr_addr = 5'd5;
    wr_data = 32'hDEAD_BEEF;
    tick();
    drive_idle();
    set_read(0, 5'd5);
    set_read(1, 5'd5);
    tick();
    for (int p = 0; p < 2; p++) begin
      vectors++;
      if (rd_data[p*32 +: 32] !== 32'hDEAD_BEEF || rd_busy[p] !== 1'b0) begin
        miscompares++;
        $display("[TB] FAIL write_read port%0d: got %h/%b, expected deadbeef/0", p, rd_data[p*32 +: 32], rd_busy[p]);
      end
    end
  endtask

  task automatic test_same_cycle_hit();
    logic [31:0] exp_hit;
`ifdef REGFILE_BYPASS_EN
    exp_hit = 32'h22;
`else
    exp_hit = 32'h11;
`endif
    drive_idle();
    wr_en   = 1'b1;
    wr_addr = 5'd7;
    wr_data = 32'h11;
    tick();
    drive_idle();
    wr_en   = 1'b1;
    wr_addr = 5'd7;
    wr_data = 32'h22;
    set_read(0, 5'd7);
    tick();
    vectors++;
    if (rd_data[31:0] !== exp_hit) begin
      miscompares++;
      $display("[TB] FAIL same_cycle_hit: got %h, expected %h", rd_data[31:0], exp_hit);
    end
    drive_idle();
    set_read(0, 5'd7);
    tick();
    vectors++;
    if (rd_data[31:0] !== 32'h22) begin
      miscompares++;
      $display("[TB] FAIL same_cycle_after: got %h, expected 00000022", rd_data[31:0]);
    end
  endtask

  task automatic test_zero_reg();
    drive_idle();
    wr_en     = 1'b1;
    wr_addr   = 5'd0;
    wr_data   = 32'hFFFF_FFFF;
    pend_set  = 1'b1;
    pend_addr = 5'd0;
    set_read(0, 5'd0);
    set_read(1, 5'd0);
    tick();
    for (int p = 0; p < 2; p++) begin
      vectors++;
      if (rd_data[p*32 +: 32] !== 32'h0 || rd_busy[p] !== 1'b0) begin
        miscompares++;
        $display("[TB] FAIL zero_reg_hit port%0d: got %h/%b, expected 0/0", p, rd_data[p*32 +: 32], rd_busy[p]);
      end
    end
    drive_idle();
    set_read(0, 5'd0);
    set_read(1, 5'd0);
    tick();
    for (int p = 0; p < 2; p++) begin
      vectors++;
      if (rd_data[p*32 +: 32] !== 32'h0 || rd_busy[p] !== 1'b0) begin
        miscompares++;
        $display("[TB] FAIL zero_reg_after port%0d: got %h/%b, expected 0/0", p, rd_data[p*32 +: 32], rd_busy[p]);
      end
    end
  endtask

  task automatic test_scoreboard();
    drive_idle();
    pend_set  = 1'b1;
    pend_addr = 5'd3;
    tick();
    drive_idle();
    set_read(1, 5'd3);
    tick();
    vectors++;
    if (rd_busy[1] !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL sb_set: got %b, expected 1", rd_busy[1]);
    end
    drive_idle();
    wr_en   = 1'b1;
    wr_addr = 5'd3;
    wr_data = 32'h3;
    tick();
    drive_idle();
    set_read(1, 5'd3);
    tick();
    vectors++;
    if (rd_busy[1] !== 1'b0 || rd_data[63:32] !== 32'h3) begin
      miscompares++;
      $display("[TB] FAIL sb_clear: got %h/%b, expected 00000003/0", rd_data[63:32], rd_busy[1]);
    end
    drive_idle();
    wr_en     = 1'b1;
    wr_addr   = 5'd3;
    wr_data   = 32'h33;
    pend_set  = 1'b1;
    pend_addr = 5'd3;
    tick();
    drive_idle();
    set_read(0, 5'd3);
    set_read(1, 5'd3);
    tick();
    for (int p = 0; p < 2; p++) begin
      vectors++;
      if (rd_busy[p] !== 1'b1 || rd_data[p*32 +: 32] !== 32'h33) begin
        miscompares++;
        $display("[TB] FAIL sb_set_wins port%0d: got %h/%b, expected 00000033/1", p, rd_data[p*32 +: 32], rd_busy[p]);
      end
    end
  endtask

  task automatic test_hold();
    drive_idle();
    wr_en   = 1'b1;
    wr_addr = 5'd9;
    wr_data = 32'h55;
    tick();
    drive_idle();
    set_read(0, 5'd9);
    set_read(1, 5'd9);
    tick();
    vectors++;
    if (rd_data[63:32] !== 32'h55) begin
      miscompares++;
      $display("[TB] FAIL hold_initial: got %h, expected 00000055", rd_data[63:32]);
    end
    drive_idle();
    set_read(0, 5'd9);
    wr_en   = 1'b1;
    wr_addr = 5'd9;
    wr_data = 32'h66;
    tick();
    drive_idle();
    set_read(0, 5'd9);
    tick();
    vectors++;
    if (rd_data[63:32] !== 32'h55 || rd_data[31:0] !== 32'h66) begin
      miscompares++;
      $display("[TB] FAIL hold_disabled: got %h %h, expected 00000055 00000066", rd_data[63:32], rd_data[31:0]);
    end
    drive_idle();
    set_read(1, 5'd9);
    tick();
    vectors++;
    if (rd_data[63:32] !== 32'h66) begin
      miscompares++;
      $display("[TB] FAIL hold_reenabled: got %h, expected 00000066", rd_data[63:32]);
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      bit narrow;
      narrow    = ($urandom_range(0, 1) == 1);
      rd_en     = 2'($urandom_range(0, 3));
      for (int p = 0; p < 2; p++) begin
        rd_addr[p*5 +: 5] = narrow ? 5'($urandom_range(0, 7)) : 5'($urandom_range(0, 31));
      end
      wr_en     = ($urandom_range(0, 2) != 0);
      wr_addr   = narrow ? 5'($urandom_range(0, 7)) : 5'($urandom_range(0, 31));
      wr_data   = $urandom;
      pend_set  = ($urandom_range(0, 3) == 0);
      pend_addr = narrow ? 5'($urandom_range(0, 7)) : 5'($urandom_range(0, 31));
      tick();
      for (int p = 0; p < 2; p++) begin
        vectors++;
        if (rd_data[p*32 +: 32] !== e_data[p] || rd_busy[p] !== e_busy[p]) begin
          miscompares++;
          $display("[TB] FAIL random cycle%0d port%0d: got %h/%b, expected %h/%b", n, p, rd_data[p*32 +: 32], rd_busy[p], e_data[p], e_busy[p]);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_same_cycle_hit();
    test_zero_reg();
    test_scoreboard();
    test_hold();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
